// File: rtl/tlb_assoc.sv
// tlb_assoc: fully-associative MIPS-style TLB with registered 1-cycle lookup,
// probe and read-back, indexed/random writes and a wired/random counter.
//
// Build option: define TLB_ASID_EN to store a per-entry ASID and qualify
// matches with (G || stored ASID == req_asid). Without it, matching is on
// VPN2 alone and G is stored but ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/vaddr/write (req_asid)  lookup request
//   resp_valid/paddr/refill/invalid/mod  lookup result, one cycle later
//   we, wr_random, wr_index, wr_data (wr_asid)  entry write
//   wired, random       random-replacement floor and current counter
//   probe_valid/vpn2 -> probe_done/hit/index  probe, one cycle later
//   rd_index -> rd_data registered entry read-back
//
// Entry layout: [63] G, [62:44] VPN2, [43:24] PFN1, [23] D1, [22] V1,
//               [21:2] PFN0, [1] D0, [0] V0.
module tlb_assoc #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_vaddr,
  input  logic              req_write,
`ifdef TLB_ASID_EN
  input  logic [ASID_W-1:0] req_asid,
  input  logic [ASID_W-1:0] wr_asid,
`endif
  output logic              resp_valid,
  output logic [31:0]       resp_paddr,
  output logic              resp_refill,
  output logic              resp_invalid,
  output logic              resp_mod,
  input  logic              we,
  input  logic              wr_random,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [63:0]       wr_data,
  input  logic [IDX_W-1:0]  wired,
  output logic [IDX_W-1:0]  random,
  input  logic              probe_valid,
  input  logic [18:0]       probe_vpn2,
  output logic              probe_done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [63:0]       rd_data
);

  if (ENTRIES < 2 || ENTRIES > 64 || IDX_W != $clog2(ENTRIES) || ASID_W < 1) begin : g_bad_cfg
    $error("tlb_assoc: invalid parameter combination");
  end

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   ENT_EXT = (IDX_W+1)'(ENTRIES);

  logic [63:0]        ent [ENTRIES];
  logic [ENTRIES-1:0] vld;
`ifdef TLB_ASID_EN
  logic [ASID_W-1:0]  asid [ENTRIES];
`endif
  logic [IDX_W-1:0]   wired_q;
  logic [IDX_W-1:0]   rnd_nx;

  logic [ENTRIES-1:0] lk_match, pr_match;
  logic               lk_hit, pr_hit;
  logic [IDX_W-1:0]   lk_idx, pr_idx;

  logic               lk_odd, sel_v, sel_d;
  logic [19:0]        sel_pfn;
  logic [31:0]        nx_paddr;
  logic               nx_refill, nx_invalid, nx_mod;

  logic [IDX_W-1:0]   wr_tgt;
  logic               wr_ok, rd_ok;

  // Parallel tag compare for lookup and probe.
  always_comb begin
    lk_match = '0;
    pr_match = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
`ifdef TLB_ASID_EN
      lk_match[i] = vld[i] && (ent[i][62:44] == req_vaddr[31:13])
                    && (ent[i][63] || (asid[i] == req_asid));
      pr_match[i] = vld[i] && (ent[i][62:44] == probe_vpn2)
                    && (ent[i][63] || (asid[i] == req_asid));
`else
      lk_match[i] = vld[i] && (ent[i][62:44] == req_vaddr[31:13]);
      pr_match[i] = vld[i] && (ent[i][62:44] == probe_vpn2);
`endif
    end
  end

  // Lowest matching index wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (lk_match[i] && !lk_hit) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (pr_match[i] && !pr_hit) begin
        pr_hit = 1'b1;
        pr_idx = IDX_W'(i);
      end
    end
  end

  // Translation and exception flags; priority refill > invalid > mod.
  always_comb begin
    lk_odd     = req_vaddr[12];
    sel_pfn    = lk_odd ? ent[lk_idx][43:24] : ent[lk_idx][21:2];
    sel_d      = lk_odd ? ent[lk_idx][23]    : ent[lk_idx][1];
    sel_v      = lk_odd ? ent[lk_idx][22]    : ent[lk_idx][0];
    nx_paddr   = '0;
    nx_refill  = 1'b0;
    nx_invalid = 1'b0;
    nx_mod     = 1'b0;
    if (req_vaddr[31:30] == 2'b10) begin
      nx_paddr = {2'b00, req_vaddr[29:0]};
    end else if (!lk_hit) begin
      nx_refill = 1'b1;
    end else if (!sel_v) begin
      nx_invalid = 1'b1;
    end else begin
      nx_paddr = {sel_pfn, req_vaddr[11:0]};
      nx_mod   = req_write && !sel_d;
    end
  end

  // Counter skips down to wired+1, then wraps; a change of wired restarts it.
  always_comb begin
    if ((wired != wired_q) || ({1'b0, random} <= ({1'b0, wired} + (IDX_W+1)'(1))))
      rnd_nx = LAST;
    else
      rnd_nx = random - IDX_W'(1);
  end

  always_comb begin
    wr_tgt = wr_random ? random : wr_index;
    wr_ok  = ({1'b0, wr_tgt} < ENT_EXT);
    rd_ok  = ({1'b0, rd_index} < ENT_EXT);
  end

  // Table and counter state. Reads above sample the array before this edge,
  // so a same-cycle write is only visible to later requests.
  always_ff @(posedge clk) begin
    wired_q <= wired;
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent[i]  <= '0;
`ifdef TLB_ASID_EN
        asid[i] <= '0;
`endif
      end
      vld    <= '0;
      random <= LAST;
    end else begin
      random <= rnd_nx;
      if (we && wr_ok) begin
        ent[wr_tgt]  <= wr_data;
        vld[wr_tgt]  <= 1'b1;
`ifdef TLB_ASID_EN
        asid[wr_tgt] <= wr_asid;
`endif
      end
    end
  end

  // Response registers; lookup/probe results hold while their valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_paddr   <= '0;
      resp_refill  <= 1'b0;
      resp_invalid <= 1'b0;
      resp_mod     <= 1'b0;
      probe_done   <= 1'b0;
      probe_hit    <= 1'b0;
      probe_index  <= '0;
      rd_data      <= '0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        resp_paddr   <= nx_paddr;
        resp_refill  <= nx_refill;
        resp_invalid <= nx_invalid;
        resp_mod     <= nx_mod;
      end
      probe_done <= probe_valid;
      if (probe_valid) begin
        probe_hit   <= pr_hit;
        probe_index <= pr_idx;
      end
      rd_data <= rd_ok ? ent[rd_index] : '0;
    end
  end

endmodule
